// File: rtl/intc_pkg.sv
// Shared types and encodings for the interrupt-controller configuration sequencer.
package intc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SETUP,
      S_ACCESS,
      S_BACKOFF,
      S_DONE
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_SLVERR  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_DUP     = 2'd3;

   localparam logic [1:0] MODE_ASC  = 2'd0;
   localparam logic [1:0] MODE_DESC = 2'd1;
   localparam logic [1:0] MODE_TBL  = 2'd2;

endpackage

// File: rtl/intc_apb_master.sv
// APB write engine: drives SETUP/ACCESS phases requested by the sequencer,
// runs the wait-state timeout and reports ok/fail for each transfer.
module intc_apb_master
   import intc_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                  pclk_i,
   input  logic                  presetn_i,
   input  logic                  setup_i,
   input  logic                  access_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pready_i,
   input  logic                  perror_i,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   output logic                  ok_o,
   output logic                  fail_o,
   output logic [1:0]            code_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_q, wait_d;
   logic          expired;

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   // The TIMEOUT-th ACCESS cycle without pready is the last one allowed.
   always_comb begin
      expired = access_i && !pready_i && (wait_q == TW'(TIMEOUT - 1));
      wait_d  = '0;
      if (access_i && !pready_i && !expired) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_comb begin
      psel_o    = setup_i || access_i;
      penable_o = access_i;
      pwrite_o  = setup_i || access_i;
      paddr_o   = (setup_i || access_i) ? addr_i : '0;
      pwdata_o  = (setup_i || access_i) ? data_i : '0;
      ok_o      = access_i && pready_i && !perror_i;
      fail_o    = access_i && ((pready_i && perror_i) || expired);
      code_o    = pready_i ? ERR_SLVERR : ERR_TIMEOUT;
   end

endmodule

// File: rtl/intc_cfg_sequencer.sv
// Programs the interrupt controller priority table over APB, one write per slot.
// Optional duplicate-priority scan of the internal table: INTC_CFG_UNIQUE_CHK_EN.
module intc_cfg_sequencer
   import intc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_INTR   = 16,
   parameter int INTR_SERV  = 4,
   parameter int TIMEOUT    = 15,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  pclk_i,
   input  logic                  presetn_i,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   input  logic                  tbl_we_i,
   input  logic [INTR_SERV-1:0]  tbl_addr_i,
   input  logic [INTR_SERV-1:0]  tbl_data_i,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   input  logic                  pready_i,
   input  logic                  perror_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o,
   output logic [INTR_SERV-1:0]  err_addr_o
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [INTR_SERV-1:0] LAST_IDX = INTR_SERV'(NUM_INTR - 1);

   state_t               state_q, state_d;
   logic [INTR_SERV-1:0] idx_q, idx_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic [1:0]           mode_q, mode_d;
   logic                 err_q, err_d;
   logic [1:0]           code_q, code_d;
   logic [INTR_SERV-1:0] eaddr_q, eaddr_d;
   logic [INTR_SERV-1:0] tbl_q [NUM_INTR];
`ifdef INTC_CFG_UNIQUE_CHK_EN
   logic [NUM_INTR-1:0]  seen_q, seen_d;
`endif

   logic [INTR_SERV-1:0] prio;
   logic                 setup, access;
   logic                 xfer_ok, xfer_fail;
   logic [1:0]           xfer_code;

   intc_apb_master #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .TIMEOUT    (TIMEOUT)
   ) u_apb (
      .pclk_i    (pclk_i),
      .presetn_i (presetn_i),
      .setup_i   (setup),
      .access_i  (access),
      .addr_i    (ADDR_WIDTH'(idx_q)),
      .data_i    (DATA_WIDTH'(prio)),
      .pready_i  (pready_i),
      .perror_i  (perror_i),
      .psel_o    (psel_o),
      .penable_o (penable_o),
      .pwrite_o  (pwrite_o),
      .paddr_o   (paddr_o),
      .pwdata_o  (pwdata_o),
      .ok_o      (xfer_ok),
      .fail_o    (xfer_fail),
      .code_o    (xfer_code)
   );

   always_comb begin
      case (mode_q)
         MODE_ASC:  prio = idx_q;
         MODE_DESC: prio = LAST_IDX - idx_q;
         default:   prio = tbl_q[idx_q];
      endcase
   end

   // Table writes are only accepted while idle so a running sequence sees a stable table.
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         for (int i = 0; i < NUM_INTR; i++) begin
            tbl_q[i] <= INTR_SERV'(i);
         end
      end else if ((state_q == S_IDLE) && tbl_we_i) begin
         tbl_q[tbl_addr_i] <= tbl_data_i;
      end
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         idx_q   <= '0;
         retry_q <= '0;
         mode_q  <= MODE_ASC;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         eaddr_q <= '0;
`ifdef INTC_CFG_UNIQUE_CHK_EN
         seen_q  <= '0;
`endif
      end else begin
         idx_q   <= idx_d;
         retry_q <= retry_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         code_q  <= code_d;
         eaddr_q <= eaddr_d;
`ifdef INTC_CFG_UNIQUE_CHK_EN
         seen_q  <= seen_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      retry_d = retry_q;
      mode_d  = mode_q;
      err_d   = err_q;
      code_d  = code_q;
      eaddr_d = eaddr_q;
`ifdef INTC_CFG_UNIQUE_CHK_EN
      seen_d  = seen_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               mode_d  = mode_i;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               eaddr_d = '0;
               idx_d   = '0;
               retry_d = '0;
`ifdef INTC_CFG_UNIQUE_CHK_EN
               seen_d  = '0;
               state_d = (mode_i >= MODE_TBL) ? S_CHECK : S_SETUP;
`else
               state_d = S_SETUP;
`endif
            end
         end
`ifdef INTC_CFG_UNIQUE_CHK_EN
         S_CHECK: begin
            if (seen_q[tbl_q[idx_q]]) begin
               err_d   = 1'b1;
               code_d  = ERR_DUP;
               eaddr_d = idx_q;
               state_d = S_DONE;
            end else begin
               seen_d[tbl_q[idx_q]] = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_SETUP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`endif
         S_SETUP: begin
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (xfer_ok) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  retry_d = '0;
                  state_d = S_SETUP;
               end
            end else if (xfer_fail) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = (xfer_code == ERR_TIMEOUT) ? S_BACKOFF : S_SETUP;
               end else begin
                  err_d   = 1'b1;
                  code_d  = xfer_code;
                  eaddr_d = idx_q;
                  state_d = S_DONE;
               end
            end
         end
         S_BACKOFF: begin
            state_d = S_SETUP;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      setup      = (state_q == S_SETUP);
      access     = (state_q == S_ACCESS);
      busy_o     = (state_q != S_IDLE);
      done_o     = (state_q == S_DONE);
      err_o      = err_q;
      err_code_o = code_q;
      err_addr_o = eaddr_q;
   end

endmodule

// File: tb/tb_intc_cfg_sequencer.sv
// Randomised bench for intc_cfg_sequencer against a slot-list reference model.
// Duplicate-check expectations follow INTC_CFG_UNIQUE_CHK_EN.
module tb_intc_cfg_sequencer;

   localparam int N = 16;
`ifdef INTC_CFG_UNIQUE_CHK_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic       pclk_i = 1'b0;
   logic       presetn_i = 1'b0;
   logic       start_i = 1'b0;
   logic [1:0] mode_i = 2'd0;
   logic       tbl_we_i = 1'b0;
   logic [3:0] tbl_addr_i = 4'd0;
   logic [3:0] tbl_data_i = 4'd0;
   logic       pready_i = 1'b0;
   logic       perror_i = 1'b0;
   logic       psel_o, penable_o, pwrite_o;
   logic [7:0] paddr_o, pwdata_o;
   logic       busy_o, done_o, err_o;
   logic [1:0] err_code_o;
   logic [3:0] err_addr_o;

   intc_cfg_sequencer dut (
      .pclk_i     (pclk_i),
      .presetn_i  (presetn_i),
      .start_i    (start_i),
      .mode_i     (mode_i),
      .tbl_we_i   (tbl_we_i),
      .tbl_addr_i (tbl_addr_i),
      .tbl_data_i (tbl_data_i),
      .psel_o     (psel_o),
      .penable_o  (penable_o),
      .pwrite_o   (pwrite_o),
      .paddr_o    (paddr_o),
      .pwdata_o   (pwdata_o),
      .pready_i   (pready_i),
      .perror_i   (perror_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .err_code_o (err_code_o),
      .err_addr_o (err_addr_o)
   );

   always #5 pclk_i = ~pclk_i;

   int checks = 0;
   int errors = 0;

   // Slave behaviour knobs and observations.
   int   ws = 0;
   int   err_slot = -1;
   bit   err_used = 0;
   bit   never_ready = 0;
   bit   poke = 0;
   int   acc_cnt, setups, acc_total, proto_bad, done_cycle, done_cnt;
   logic [7:0] setup_addr, setup_data;
   int   got_addr[$], got_data[$];
   bit   got_err[$];
   int   exp_addr[$], exp_data[$];
   bit   exp_err[$];
   int   tbl_m[N];

   function automatic int prio_of(input int mode, input int i);
      if (mode == 0) return i;
      if (mode == 1) return N - 1 - i;
      return tbl_m[i];
   endfunction

   function automatic void build_expected(input int mode, input int eslot);
      exp_addr.delete(); exp_data.delete(); exp_err.delete();
      for (int i = 0; i < N; i++) begin
         if (i == eslot) begin
            exp_addr.push_back(i); exp_data.push_back(prio_of(mode, i)); exp_err.push_back(1'b1);
         end
         exp_addr.push_back(i); exp_data.push_back(prio_of(mode, i)); exp_err.push_back(1'b0);
      end
   endfunction

   function automatic int exp_done(input int nxfer, input int wstates, input int mode);
      return nxfer * (2 + wstates) + 1 + ((CHK == 1 && mode >= 2) ? N : 0);
   endfunction

   task automatic slave_step();
      if (psel_o && !penable_o) begin
         setups++;
         acc_cnt = 0;
         setup_addr = paddr_o;
         setup_data = pwdata_o;
         if (!pwrite_o) proto_bad++;
         pready_i = 1'b0;
         perror_i = 1'b0;
      end else if (psel_o && penable_o) begin
         acc_total++;
         acc_cnt++;
         if (paddr_o !== setup_addr || pwdata_o !== setup_data || !pwrite_o) proto_bad++;
         if (!never_ready && acc_cnt > ws) begin
            pready_i = 1'b1;
            perror_i = (int'(paddr_o) == err_slot) && !err_used;
            if (perror_i) err_used = 1'b1;
            got_addr.push_back(int'(paddr_o));
            got_data.push_back(int'(pwdata_o));
            got_err.push_back(perror_i);
         end else begin
            pready_i = 1'b0;
            perror_i = 1'($urandom_range(0, 1));
         end
      end else begin
         pready_i = 1'b0;
         perror_i = 1'b0;
         if (penable_o || pwrite_o || paddr_o !== 8'd0 || pwdata_o !== 8'd0) proto_bad++;
      end
   endtask

   task automatic load_tbl(input int idx, input int val);
      @(negedge pclk_i);
      tbl_we_i = 1'b1; tbl_addr_i = 4'(idx); tbl_data_i = 4'(val);
      @(posedge pclk_i); #1;
      tbl_we_i = 1'b0;
      tbl_m[idx] = val;
   endtask

   task automatic load_perm();
      int tmp, j;
      for (int i = 0; i < N; i++) tbl_m[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = tbl_m[i]; tbl_m[i] = tbl_m[j]; tbl_m[j] = tmp;
      end
      for (int i = 0; i < N; i++) load_tbl(i, tbl_m[i]);
   endtask

   // Leaves the caller at edge 0 + 1 time unit, i.e. sampling cycle 1.
   task automatic start_seq(input int mode, input bit wr, input int wa, input int wd);
      setups = 0; acc_total = 0; proto_bad = 0; done_cnt = 0; acc_cnt = 0; err_used = 0;
      got_addr.delete(); got_data.delete(); got_err.delete();
      @(negedge pclk_i);
      start_i = 1'b1;
      mode_i = 2'(mode);
      if (wr) begin
         tbl_we_i = 1'b1; tbl_addr_i = 4'(wa); tbl_data_i = 4'(wd);
         tbl_m[wa] = wd;
      end
      @(posedge pclk_i); #1;
      start_i = 1'b0;
      tbl_we_i = 1'b0;
   endtask

   task automatic run_seq(input int max_cyc);
      int cyc;
      cyc = 1;
      done_cycle = -1;
      while (cyc <= max_cyc) begin
         slave_step();
         if (done_o) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (poke && cyc == 3) begin
            start_i = 1'b1; mode_i = 2'd0;
            tbl_we_i = 1'b1; tbl_addr_i = 4'd12; tbl_data_i = ~4'(tbl_m[12]);
         end else if (poke && cyc == 4) begin
            start_i = 1'b0; tbl_we_i = 1'b0;
         end
         if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
         @(posedge pclk_i); #1;
         cyc++;
      end
      pready_i = 1'b0;
      perror_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge pclk_i);
      #1;
      checks++;
      if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, busy_o, done_o, err_o, err_code_o, err_addr_o} !== 28'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got psel=%b pen=%b busy=%b err=%b code=%0d, required all zero", psel_o, penable_o, busy_o, err_o, err_code_o);
      end
      @(negedge pclk_i);
      presetn_i = 1'b1;
      for (int i = 0; i < N; i++) tbl_m[i] = i;
      @(posedge pclk_i); #1;
      checks++;
      if ({psel_o, busy_o, done_o, err_o} !== 4'd0) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: got psel=%b busy=%b done=%b err=%b, required 0", psel_o, busy_o, done_o, err_o);
      end
   endtask

   task automatic test_ascending();
      ws = 0; err_slot = -1; never_ready = 0; poke = 0;
      start_seq(0, 0, 0, 0);
      run_seq(200);
      build_expected(0, -1);
      checks++;
      if (got_addr.size() !== exp_addr.size()) begin
         errors++; $display("[TB] FAIL asc_count: got %0d writes, required %0d", got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_err[i] !== exp_err[i]) begin
            errors++;
            $display("[TB] FAIL asc_xfer%0d: got a=%0d d=%0d e=%0d, required a=%0d d=%0d e=%0d", i, got_addr[i], got_data[i], got_err[i], exp_addr[i], exp_data[i], exp_err[i]);
         end
      end
      checks++;
      if (done_cycle !== 33 || done_cnt !== 1) begin
         errors++; $display("[TB] FAIL asc_done: got cycle %0d pulses %0d, required cycle 33 pulses 1", done_cycle, done_cnt);
      end
      checks++;
      if ({err_o, err_code_o, busy_o} !== 4'd0 || proto_bad !== 0) begin
         errors++; $display("[TB] FAIL asc_status: got err=%b code=%0d busy=%b proto=%0d, required 0", err_o, err_code_o, busy_o, proto_bad);
      end
   endtask

   task automatic test_descending();
      ws = 2; err_slot = -1; never_ready = 0; poke = 0;
      start_seq(1, 0, 0, 0);
      run_seq(300);
      build_expected(1, -1);
      checks++;
      if (got_addr.size() !== exp_addr.size()) begin
         errors++; $display("[TB] FAIL desc_count: got %0d writes, required %0d", got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_err[i] !== exp_err[i]) begin
            errors++;
            $display("[TB] FAIL desc_xfer%0d: got a=%0d d=%0d, required a=%0d d=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
      checks++;
      if (done_cycle !== 65 || done_cnt !== 1 || err_o !== 1'b0 || proto_bad !== 0) begin
         errors++; $display("[TB] FAIL desc_done: got cycle %0d err=%b proto=%0d, required cycle 65 err=0 proto=0", done_cycle, err_o, proto_bad);
      end
   endtask

   task automatic test_table_retry();
      load_perm();
      ws = 0; err_slot = 5; never_ready = 0; poke = 1;
      start_seq(2, 0, 0, 0);
      run_seq(300);
      poke = 0;
      build_expected(2, 5);
      checks++;
      if (got_addr.size() !== 17) begin
         errors++; $display("[TB] FAIL tbl_count: got %0d writes, required 17", got_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_err[i] !== exp_err[i]) begin
            errors++;
            $display("[TB] FAIL tbl_xfer%0d: got a=%0d d=%0d e=%0d, required a=%0d d=%0d e=%0d", i, got_addr[i], got_data[i], got_err[i], exp_addr[i], exp_data[i], exp_err[i]);
         end
      end
      checks++;
      if (done_cycle !== exp_done(17, 0, 2) || done_cnt !== 1 || err_o !== 1'b0) begin
         errors++; $display("[TB] FAIL tbl_done: got cycle %0d pulses %0d err=%b, required cycle %0d pulses 1 err=0", done_cycle, done_cnt, err_o, exp_done(17, 0, 2));
      end
   endtask

   task automatic test_timeout();
      ws = 0; err_slot = -1; never_ready = 1; poke = 0;
      start_seq(0, 0, 0, 0);
      run_seq(300);
      never_ready = 0;
      checks++;
      if (setups !== 4 || acc_total !== 60 || got_addr.size() !== 0) begin
         errors++; $display("[TB] FAIL to_attempts: got setups=%0d access=%0d writes=%0d, required 4/60/0", setups, acc_total, got_addr.size());
      end
      checks++;
      if (done_cycle !== 68 || done_cnt !== 1) begin
         errors++; $display("[TB] FAIL to_done: got cycle %0d pulses %0d, required cycle 68 pulses 1", done_cycle, done_cnt);
      end
      checks++;
      if (err_o !== 1'b1 || err_code_o !== 2'd2 || err_addr_o !== 4'd0) begin
         errors++; $display("[TB] FAIL to_status: got err=%b code=%0d addr=%0d, required 1/2/0", err_o, err_code_o, err_addr_o);
      end
   endtask

   task automatic test_duplicate();
      for (int i = 0; i < N; i++) load_tbl(i, i);
      load_tbl(3, 7);
      load_tbl(7, 3);
      ws = 0; err_slot = -1; never_ready = 0; poke = 0;
      start_seq(2, 1, 9, 7);
      run_seq(200);
`ifdef INTC_CFG_UNIQUE_CHK_EN
      checks++;
      if (setups !== 0 || got_addr.size() !== 0 || done_cycle !== 11) begin
         errors++; $display("[TB] FAIL dup_traffic: got setups=%0d done=%0d, required 0 and cycle 11", setups, done_cycle);
      end
      checks++;
      if (err_o !== 1'b1 || err_code_o !== 2'd3 || err_addr_o !== 4'd9) begin
         errors++; $display("[TB] FAIL dup_status: got err=%b code=%0d addr=%0d, required 1/3/9", err_o, err_code_o, err_addr_o);
      end
`else
      build_expected(2, -1);
      checks++;
      if (got_addr.size() !== exp_addr.size()) begin
         errors++; $display("[TB] FAIL dup_count: got %0d writes, required %0d", got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            errors++; $display("[TB] FAIL dup_xfer%0d: got a=%0d d=%0d, required a=%0d d=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
      checks++;
      if (err_o !== 1'b0 || err_code_o !== 2'd0 || done_cycle !== 33) begin
         errors++; $display("[TB] FAIL dup_status: got err=%b code=%0d done=%0d, required 0/0/33", err_o, err_code_o, done_cycle);
      end
`endif
   endtask

   task automatic test_random();
      int mode, slot, nx;
      load_perm();
      for (int it = 0; it < 4; it++) begin
         mode = $urandom_range(0, 3);
         ws = $urandom_range(0, 3);
         slot = $urandom_range(0, N);
         err_slot = (slot == N) ? -1 : slot;
         never_ready = 0; poke = 0;
         start_seq(mode, 0, 0, 0);
         run_seq(400);
         build_expected(mode, err_slot);
         nx = exp_addr.size();
         checks++;
         if (got_addr.size() !== nx) begin
            errors++; $display("[TB] FAIL rnd%0d_count: got %0d writes, required %0d", it, got_addr.size(), nx);
         end
         for (int i = 0; i < nx && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_err[i] !== exp_err[i]) begin
               errors++;
               $display("[TB] FAIL rnd%0d_xfer%0d: got a=%0d d=%0d e=%0d, required a=%0d d=%0d e=%0d", it, i, got_addr[i], got_data[i], got_err[i], exp_addr[i], exp_data[i], exp_err[i]);
            end
         end
         checks++;
         if (done_cycle !== exp_done(nx, ws, mode) || err_o !== 1'b0 || proto_bad !== 0) begin
            errors++; $display("[TB] FAIL rnd%0d_done: got cycle %0d err=%b proto=%0d, required cycle %0d err=0 proto=0", it, done_cycle, err_o, proto_bad, exp_done(nx, ws, mode));
         end
      end
      err_slot = -1;
   endtask

   task automatic test_reset_mid();
      bit found;
      ws = 0; err_slot = -1; never_ready = 0; poke = 0;
      found = 0;
      start_seq(0, 0, 0, 0);
      for (int c = 0; c < 40 && !found; c++) begin
         slave_step();
         if (psel_o && penable_o && paddr_o == 8'd8) found = 1;
         else begin
            @(posedge pclk_i); #1;
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("[TB] FAIL rst_reach_slot8: got no ACCESS on slot 8, required one within 40 cycles");
      end
      #2;
      presetn_i = 1'b0;
      #1;
      checks++;
      if ({psel_o, penable_o, busy_o, done_o, err_o, paddr_o} !== 13'd0) begin
         errors++; $display("[TB] FAIL rst_async_idle: got psel=%b pen=%b busy=%b done=%b addr=%0d, required 0", psel_o, penable_o, busy_o, done_o, paddr_o);
      end
      pready_i = 1'b0;
      perror_i = 1'b0;
      @(negedge pclk_i);
      presetn_i = 1'b1;
      for (int i = 0; i < N; i++) tbl_m[i] = i;
      start_seq(2, 0, 0, 0);
      run_seq(200);
      build_expected(2, -1);
      checks++;
      if (got_addr.size() !== N || (got_addr.size() > 0 && got_addr[0] !== 0)) begin
         errors++; $display("[TB] FAIL rst_restart: got %0d writes, required 16 from slot 0", got_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         checks++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            errors++; $display("[TB] FAIL rst_xfer%0d: got a=%0d d=%0d, required a=%0d d=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
         end
      end
      checks++;
      if (done_cycle !== exp_done(N, 0, 2) || done_cnt !== 1) begin
         errors++; $display("[TB] FAIL rst_done: got cycle %0d, required %0d", done_cycle, exp_done(N, 0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_descending();
      test_table_retry();
      test_timeout();
      test_duplicate();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
